// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// Optional saturation to 9999: define BIN2BCD_SAT_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk_100mhz,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  over_9999
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] bin_sr;
  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] cap;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_n;
  logic [SW-1:0]    result;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             big;

  // State register
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_n   = state;
    bin_ready = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        bin_ready = 1'b1;
        if (bin_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Add 3 to every digit >= 5, then shift the joint register left
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    {scratch_n, bin_n} = {adj, bin_sr} << 1;
  end

  assign big = 32'(cap) > 32'd9999;

  // Final digits, optionally clamped to 9999
  always_comb begin
    result = scratch_n;
`ifdef BIN2BCD_SAT_EN
    if (big) begin
      for (int i = 0; i < DIGITS; i++) begin
        result[4*i +: 4] = (i < 4) ? 4'd9 : 4'd0;
      end
    end
`endif
  end

  // Datapath: load on accept, iterate in SHIFT, publish on last shift
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr    <= '0;
      cap       <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      over_9999 <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (accept) begin
        bin_sr  <= bin_in;
        cap     <= bin_in;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        bin_sr  <= bin_n;
        scratch <= scratch_n;
        cnt     <= cnt - CW'(1);
        if (last) begin
          bcd_out   <= result;
          over_9999 <= big;
          bcd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq.
// Honours BIN2BCD_SAT_EN when the build defines it.
module tb_bin2bcd_seq;

  typedef struct {
    logic [19:0] bcd;
    logic        ov;
    int          acc;
  } exp_t;

  logic        clk_100mhz;
  logic        reset_n;
  logic [15:0] bin_in;
  logic        bin_valid;
  logic        bin_ready;
  logic [19:0] bcd_out;
  logic        bcd_valid;
  logic        over_9999;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   cyc;
  int   acc_a;
  int   acc_b;
  int   acc_c;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk_100mhz(clk_100mhz),
    .reset_n(reset_n),
    .bin_in(bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .bcd_out(bcd_out),
    .bcd_valid(bcd_valid),
    .over_9999(over_9999)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               nm, act, req);
    end
  endtask

  function automatic logic [19:0] model(input int v);
    logic [19:0] b;
    int t;
    t = v;
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef BIN2BCD_SAT_EN
    if (v > 9999) b = 20'h09999;
`endif
    return b;
  endfunction

  // Drive one request; push its expectation before accept
  task automatic send(input logic [15:0] v,
                      input logic [19:0] eb,
                      input logic        eo,
                      input bit          hold,
                      output int         acc);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk_100mhz);
    bin_in = v;
    bin_valid = 1'b1;
    while (!bin_ready && n < 100) begin
      @(negedge clk_100mhz);
      n++;
    end
    acc = cyc;
    if (!bin_ready) begin
      chk("ready_timeout", 32'(bin_ready), 32'd1);
    end else begin
      e.bcd = eb;
      e.ov  = eo;
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk_100mhz);
    #1;
    if (!hold) bin_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk_100mhz);
  endtask

  // Monitor: pop and compare on each result pulse
  always @(negedge clk_100mhz) begin
    exp_t e;
    if (reset_n) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dut.scratch[4*i +: 4] > 4'd9) begin
          failures++;
          $display("FAIL digit_range: got %h want <=9",
                   dut.scratch[4*i +: 4]);
        end
      end
      if (bcd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(bcd_out), 32'hffffffff);
        end else begin
          e = exp_q.pop_front();
          chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
          chk("over_9999", 32'(over_9999), 32'(e.ov));
          chk("latency", 32'(cyc - e.acc), 32'd17);
        end
      end
    end
  end

  initial begin
    int a;
    int v;
    logic [19:0] eb;
    checks = 0;
    failures = 0;
    cyc = 0;
    reset_n = 1'b0;
    bin_in = '0;
    bin_valid = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_ov", 32'(over_9999), 32'd0);
    chk("rst_ready", 32'(bin_ready), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_100mhz);

    send(16'd6765, 20'h06765, 1'b0, 1'b0, a);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_100mhz);
      chk("busy_ready", 32'(bin_ready), 32'd0);
    end
    drain();

    send(16'd0, 20'h00000, 1'b0, 1'b0, a);
    send(16'd9999, 20'h09999, 1'b0, 1'b0, a);
`ifdef BIN2BCD_SAT_EN
    send(16'd10000, 20'h09999, 1'b1, 1'b0, a);
    send(16'd65535, 20'h09999, 1'b1, 1'b0, a);
`else
    send(16'd10000, 20'h10000, 1'b1, 1'b0, a);
    send(16'd65535, 20'h65535, 1'b1, 1'b0, a);
`endif
    drain();

    send(16'd1, 20'h00001, 1'b0, 1'b1, acc_a);
    send(16'd2, 20'h00002, 1'b0, 1'b1, acc_b);
    send(16'd3, 20'h00003, 1'b0, 1'b0, acc_c);
    chk("spacing_ab", 32'(acc_b - acc_a), 32'd18);
    chk("spacing_bc", 32'(acc_c - acc_b), 32'd18);
    drain();

    send(16'd4321, 20'h04321, 1'b0, 1'b0, a);
    repeat (3) @(negedge clk_100mhz);
    bin_in = 16'd1111;
    bin_valid = 1'b1;
    @(negedge clk_100mhz);
    bin_valid = 1'b0;
    bin_in = '0;
    drain();

    @(negedge clk_100mhz);
    bin_in = 16'd5555;
    bin_valid = 1'b1;
    @(posedge clk_100mhz);
    #1;
    bin_valid = 1'b0;
    repeat (5) @(posedge clk_100mhz);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_ov", 32'(over_9999), 32'd0);
    chk("abort_valid", 32'(bcd_valid), 32'd0);
    chk("abort_ready", 32'(bin_ready), 32'd1);
    repeat (2) @(negedge clk_100mhz);
    reset_n = 1'b1;
    repeat (25) @(negedge clk_100mhz);
    send(16'd1234, 20'h01234, 1'b0, 1'b0, a);
    drain();

    for (int k = 0; k < 1000; k++) begin
      v = int'($urandom_range(0, 65535));
      eb = model(v);
      send(16'(v), eb, v > 9999, 1'b0, a);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the seven-segment display driver. It takes the processor's display value (the lower bits of display_reg) and delivers packed BCD digits. The display mux can then select digits directly, with no combinational divide/modulo. It uses a one-value handshake: the input is accepted only when idle, and the result is presented with a one-cycle valid pulse.

Parameters:
WIDTH, 16, binary input width in bits; the iteration count equals WIDTH.
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
clk_100mhz  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
bin_in  input  WIDTH  binary value to convert; sampled only on the accept edge.
bin_valid  input  1  request; the value is accepted when bin_valid and bin_ready are both high on a clock edge.
bin_ready  output  1  high only in IDLE.
bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) is in [3:0]; holds the last result.
bcd_valid  output  1  one-cycle pulse when bcd_out has just been updated.
over_9999  output  1  last result exceeded 9999; registered together with bcd_out.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - bcd_out=0, bcd_valid=0, over_9999=0, bin_ready=1 once in IDLE.
  - The shift register and iteration counter clear.
  - A conversion in progress is aborted; no bcd_valid is produced for it.
- State machine:
  - IDLE:
    - bin_ready=1.
    - On the accept edge: load the binary shift register with bin_in, clear the BCD scratch register, load iteration counter = WIDTH, go to SHIFT.
  - SHIFT:
    - bin_ready=0.
    - Each cycle, every scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
    - The concatenated {scratch, binary} register then shifts left by 1.
    - The counter decrements; when it reaches 1 on this edge, go to DONE.
    - Exactly WIDTH SHIFT cycles occur.
  - DONE:
    - Register the scratch digits to bcd_out.
    - over_9999 = (binary value > 9999), computed from the captured input.
    - bcd_valid=1 for this single cycle; return to IDLE.
- Latency:
  - Accept edge at cycle T; bcd_valid high during cycle T+WIDTH+1 (T+17 at defaults).
  - Throughput: one conversion per WIDTH+2 cycles. Back-to-back input is accepted the cycle after DONE.
- bin_valid while busy is ignored and not queued; the producer must hold it until it sees bin_ready.
- bin_in changes after the accept edge have no effect on the current conversion.
- bcd_out never shows partial results; it changes only in DONE.
- Every scratch digit stays in 0..9 at all times; a digit value >9 is a design error (assertion in the bench).
- Boundaries:
  - Input 0 gives all-zero digits.
  - Input 2^WIDTH-1 gives 65535 at defaults with over_9999=1.
  - Input 9999 gives over_9999=0; input 10000 gives over_9999=1.

Optional Feature:
Macro BIN2BCD_SAT_EN.
- Defined: when the captured value > 9999, bcd_out is forced to digits 0,9,9,9,9 (packed 0x09999) and over_9999=1. The 4-digit display then saturates instead of showing truncated high digits.
- Not defined: bcd_out is always the exact conversion; over_9999 is still reported.
- The latency and handshake are identical in both builds.

Test Plan:
- Reset, then bin_in=6765 with bin_valid pulsed 1 cycle in IDLE -> bcd_valid exactly 17 cycles after accept, bcd_out=0x06765, over_9999=0, bin_ready low during SHIFT/DONE.
- bin_in=0 -> bcd_out=0x00000; bin_in=9999 -> 0x09999, over_9999=0; bin_in=10000 -> 0x10000, over_9999=1 (SAT build: 0x09999, over_9999=1).
- bin_in=65535 -> non-SAT build 0x65535, over_9999=1; SAT build 0x09999, over_9999=1.
- bin_valid held high continuously with a new value on each accept (1, 2, 3) -> accepts spaced exactly 18 cycles apart, results 0x00001, 0x00002, 0x00003 in order, no drops.
- Change bin_in and pulse bin_valid during SHIFT -> request ignored, result matches the originally accepted value.
- Assert reset_n low 5 cycles into a conversion -> outputs zero immediately (no clock needed), no bcd_valid pulse; after release, a new 1234 request -> 0x01234.
- Randomised check of 1000 values against a divide/modulo model, plus a digit-range assertion on the scratch digits every cycle.
